multi_unit_cdb_arbiter: RTL and testbench
=========================================

MULTI_UNIT_CDB_ARBITER -- requirements
Module: multi_unit_cdb_arbiter

Interface
REQ-001 Parameter WIDTH, default 31, SHALL be the MSB index of result data (data is WIDTH+1 bits).
REQ-002 Parameter ROB, default 2, SHALL be the MSB index of the ROB tag.
REQ-003 Parameter CONTROL, default 6, SHALL be the MSB index of the per-result control field (branch redirect info).
REQ-004 Parameter CHANNELS, default 3, SHALL be the number of functional units (2..8).
REQ-005 Parameter DEPTH, default 2, SHALL be the per-channel buffer depth (power of two, 1..8).
REQ-006 Parameter PRIO_MODE, default 1: 0 = pure round-robin; 1 = channel 0 (branch unit) fixed-highest, round-robin among the rest.
REQ-007 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-008 Port globalReset, input, 1: reset, synchronous and active-low.
REQ-009 Port reqValid, input, CHANNELS: per-unit result valid.
REQ-010 Port reqReady, output, CHANNELS: per-unit buffer can accept.
REQ-011 Port reqData, input, CHANNELS*(WIDTH+1): packed results, channel i at slice i.
REQ-012 Port reqRob, input, CHANNELS*(ROB+1): packed ROB tags.
REQ-013 Port reqControl, input, CHANNELS*(CONTROL+1): packed control fields.
REQ-014 Port flush, input, 1: mispredict flush.
REQ-015 Ports cdbValid (1), cdbData (WIDTH+1), cdbRob (ROB+1), cdbControl (CONTROL+1), cdbSource ($clog2(CHANNELS)), outputs: registered common-data-bus broadcast.

Function
REQ-016 Each channel SHALL own a FIFO of DEPTH entries {data,rob,control}; enqueue when reqValid[i] && reqReady[i].
REQ-017 reqReady[i] SHALL be 1 iff channel i occupancy < DEPTH, from registered count only (no same-cycle dequeue bypass).
REQ-018 Each cycle at most one non-empty channel SHALL be granted; its head is dequeued and loaded into the CDB registers at the same edge.
REQ-019 cdbValid SHALL be 1 in the cycle after a grant and 0 in cycles following no grant; cdb* fields SHALL hold last values when cdbValid is 0.
REQ-020 Minimum latency: entry enqueued at edge N SHALL appear on CDB after edge N+1 (an empty buffer does not bypass).
REQ-021 Round-robin: pointer holds last granted channel; search SHALL start at pointer+1 modulo CHANNELS; pointer updates to granted channel only on grant.
REQ-022 PRIO_MODE=1: channel 0 SHALL win whenever non-empty, without updating the pointer; otherwise round-robin over channels 1..CHANNELS-1.
REQ-023 Simultaneous enqueue and dequeue on one channel SHALL keep occupancy unchanged; FIFO pointers wrap modulo DEPTH.
REQ-024 flush=1 SHALL, at that edge, empty every FIFO, drop same-cycle enqueues, and clear cdbValid; the round-robin pointer is retained.
REQ-025 cdbSource SHALL equal the binary index of the granted channel.
REQ-026 No entry SHALL be lost, duplicated or reordered within a channel absent flush.

Reset
REQ-027 globalReset=0 at a rising edge SHALL clear all FIFO counts and pointers, set cdbValid=0, cdbData/cdbRob/cdbControl/cdbSource=0, round-robin pointer=CHANNELS-1; reset overrides flush and enqueue.
REQ-028 During and after reset, until an enqueue, reqReady SHALL be all ones.

Verification
REQ-029 After reset, reqValid=3'b010, reqData[1]=0x1234, reqRob[1]=5 for one cycle -> two edges later cdbValid=1, cdbData=0x1234, cdbRob=5, cdbSource=1, then cdbValid=0.
REQ-030 PRIO_MODE=0, all three channels valid one cycle -> CDB order sources 0,1,2 on consecutive cycles.
REQ-031 PRIO_MODE=1, channel 0 valid every cycle plus channels 1,2 once -> channel 0 granted each cycle, 1 and 2 granted only after channel 0 empties, in order 1,2.
REQ-032 DEPTH=2, channel 2 valid 4 consecutive cycles while channel 0 saturates grants -> reqReady[2]=0 after 2 accepts; accepted values later emerge in order.
REQ-033 Buffers partly full, flush=1 with reqValid high -> next cycle cdbValid=0, reqReady all ones, nothing of pre-flush data ever broadcast.
REQ-034 globalReset=0 asserted mid-traffic with flush=1 -> all outputs at reset values next cycle; first post-reset grant goes to channel 0.

Source files
------------

// File: rtl/multi_unit_cdb_arbiter.sv
// Multi-unit common-data-bus arbiter.
// Each functional unit pushes results into its own small FIFO. One head entry
// per cycle is selected and broadcast on a registered common data bus. The
// selection is round-robin, and channel 0 (the branch unit) can be given
// fixed priority. A flush empties every FIFO and squashes the broadcast.
module multi_unit_cdb_arbiter #(
    parameter int WIDTH     = 31,
    parameter int ROB       = 2,
    parameter int CONTROL   = 6,
    parameter int CHANNELS  = 3,
    parameter int DEPTH     = 2,
    parameter int PRIO_MODE = 1
) (
    input  logic                              clk,
    input  logic                              globalReset,
    input  logic [CHANNELS-1:0]               reqValid,
    output logic [CHANNELS-1:0]               reqReady,
    input  logic [CHANNELS*(WIDTH+1)-1:0]     reqData,
    input  logic [CHANNELS*(ROB+1)-1:0]       reqRob,
    input  logic [CHANNELS*(CONTROL+1)-1:0]   reqControl,
    input  logic                              flush,
    output logic                              cdbValid,
    output logic [WIDTH:0]                    cdbData,
    output logic [ROB:0]                      cdbRob,
    output logic [CONTROL:0]                  cdbControl,
    output logic [$clog2(CHANNELS)-1:0]       cdbSource
);

    localparam int DW   = WIDTH + 1;
    localparam int RW   = ROB + 1;
    localparam int CW   = CONTROL + 1;
    localparam int EW   = DW + RW + CW;
    localparam int SW   = $clog2(CHANNELS);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [PW-1:0]   LAST_C  = PW'(DEPTH - 1);

    // Per-channel FIFO state
    logic [EW-1:0]   mem_q    [CHANNELS][DEPTH];
    logic [EW-1:0]   mem_d    [CHANNELS][DEPTH];
    logic [PW-1:0]   wr_ptr_q [CHANNELS];
    logic [PW-1:0]   wr_ptr_d [CHANNELS];
    logic [PW-1:0]   rd_ptr_q [CHANNELS];
    logic [PW-1:0]   rd_ptr_d [CHANNELS];
    logic [CNTW-1:0] count_q  [CHANNELS];
    logic [CNTW-1:0] count_d  [CHANNELS];

    // Arbitration and broadcast state
    logic [SW-1:0]   rr_q, rr_d;
    logic            cdb_valid_q, cdb_valid_d;
    logic [DW-1:0]   cdb_data_q, cdb_data_d;
    logic [RW-1:0]   cdb_rob_q, cdb_rob_d;
    logic [CW-1:0]   cdb_control_q, cdb_control_d;
    logic [SW-1:0]   cdb_source_q, cdb_source_d;

    logic [CHANNELS-1:0] nonempty_s;
    logic                grant_found_s;
    logic                grant_s;
    logic [SW-1:0]       grant_idx_s;
    logic [EW-1:0]       head_s;

    // Advance a FIFO pointer, wrapping at DEPTH
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        if (ptr == LAST_C) begin
            return '0;
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Ready depends only on registered occupancy
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            reqReady[i]   = (count_q[i] < DEPTH_C);
            nonempty_s[i] = (count_q[i] != '0);
        end
    end

    // Pick one non-empty channel: optional fixed priority for channel 0, then round-robin after rr_q
    always_comb begin
        int cand;
        cand          = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        if ((PRIO_MODE == 1) && nonempty_s[0]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = '0;
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                cand = (int'(rr_q) + k) % CHANNELS;
                if (!grant_found_s && nonempty_s[cand] &&
                    !((PRIO_MODE == 1) && (cand == 0))) begin
                    grant_found_s = 1'b1;
                    grant_idx_s   = SW'(cand);
                end else begin
                    grant_found_s = grant_found_s;
                end
            end
        end
        grant_s = grant_found_s && !flush;
        head_s  = mem_q[grant_idx_s][rd_ptr_q[grant_idx_s]];
    end

    // FIFO next-state: enqueue, dequeue on grant, flush empties everything
    always_comb begin
        logic enq;
        logic deq;
        mem_d = mem_q;
        for (int i = 0; i < CHANNELS; i++) begin
            enq         = reqValid[i] && reqReady[i] && !flush;
            deq         = grant_s && (grant_idx_s == SW'(i));
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end else begin
                if (enq) begin
                    mem_d[i][wr_ptr_q[i]] = {reqData[i*DW +: DW],
                                             reqRob[i*RW +: RW],
                                             reqControl[i*CW +: CW]};
                    wr_ptr_d[i] = next_ptr(wr_ptr_q[i]);
                end else begin
                    wr_ptr_d[i] = wr_ptr_q[i];
                end
                if (deq) begin
                    rd_ptr_d[i] = next_ptr(rd_ptr_q[i]);
                end else begin
                    rd_ptr_d[i] = rd_ptr_q[i];
                end
                case ({enq, deq})
                    2'b10:   count_d[i] = count_q[i] + CNTW'(1);
                    2'b01:   count_d[i] = count_q[i] - CNTW'(1);
                    default: count_d[i] = count_q[i];
                endcase
            end
        end
    end

    // Broadcast register and round-robin pointer next-state
    always_comb begin
        cdb_valid_d   = 1'b0;
        cdb_data_d    = cdb_data_q;
        cdb_rob_d     = cdb_rob_q;
        cdb_control_d = cdb_control_q;
        cdb_source_d  = cdb_source_q;
        rr_d          = rr_q;
        if (grant_s) begin
            cdb_valid_d   = 1'b1;
            cdb_data_d    = head_s[EW-1 -: DW];
            cdb_rob_d     = head_s[CW +: RW];
            cdb_control_d = head_s[CW-1:0];
            cdb_source_d  = grant_idx_s;
            if ((PRIO_MODE == 1) && (grant_idx_s == '0)) begin
                rr_d = rr_q;
            end else begin
                rr_d = grant_idx_s;
            end
        end else begin
            cdb_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!globalReset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_q          <= SW'(CHANNELS - 1);
            cdb_valid_q   <= 1'b0;
            cdb_data_q    <= '0;
            cdb_rob_q     <= '0;
            cdb_control_q <= '0;
            cdb_source_q  <= '0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rr_q          <= rr_d;
            cdb_valid_q   <= cdb_valid_d;
            cdb_data_q    <= cdb_data_d;
            cdb_rob_q     <= cdb_rob_d;
            cdb_control_q <= cdb_control_d;
            cdb_source_q  <= cdb_source_d;
        end
    end

    assign cdbValid   = cdb_valid_q;
    assign cdbData    = cdb_data_q;
    assign cdbRob     = cdb_rob_q;
    assign cdbControl = cdb_control_q;
    assign cdbSource  = cdb_source_q;

endmodule

// File: tb/tb_multi_unit_cdb_arbiter.sv
// Directed bench for multi_unit_cdb_arbiter: one instance with branch-unit
// priority, one pure round-robin instance, both fed the same stimulus.
module tb_multi_unit_cdb_arbiter;

    logic        clk;
    logic        globalReset;
    logic [2:0]  reqValid;
    logic [95:0] reqData;
    logic [8:0]  reqRob;
    logic [20:0] reqControl;
    logic        flush;

    logic [2:0]  p_ready, r_ready;
    logic        p_valid, r_valid;
    logic [31:0] p_data,  r_data;
    logic [2:0]  p_rob,   r_rob;
    logic [6:0]  p_ctrl,  r_ctrl;
    logic [1:0]  p_src,   r_src;

    int vectors     = 0;
    int miscompares = 0;

    multi_unit_cdb_arbiter #(.PRIO_MODE(1)) dut_p (
        .clk(clk), .globalReset(globalReset), .reqValid(reqValid), .reqReady(p_ready),
        .reqData(reqData), .reqRob(reqRob), .reqControl(reqControl), .flush(flush),
        .cdbValid(p_valid), .cdbData(p_data), .cdbRob(p_rob), .cdbControl(p_ctrl),
        .cdbSource(p_src)
    );

    multi_unit_cdb_arbiter #(.PRIO_MODE(0)) dut_r (
        .clk(clk), .globalReset(globalReset), .reqValid(reqValid), .reqReady(r_ready),
        .reqData(reqData), .reqRob(reqRob), .reqControl(reqControl), .flush(flush),
        .cdbValid(r_valid), .cdbData(r_data), .cdbRob(r_rob), .cdbControl(r_ctrl),
        .cdbSource(r_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] d, input logic [2:0] r, input logic [6:0] c);
        reqData[ch*32 +: 32]  = d;
        reqRob[ch*3 +: 3]     = r;
        reqControl[ch*7 +: 7] = c;
    endtask

    task automatic do_reset();
        globalReset = 1'b0;
        flush       = 1'b0;
        reqValid    = 3'b000;
        step();
        step();
        globalReset = 1'b1;
    endtask

    initial begin
        globalReset = 1'b0;
        flush       = 1'b0;
        reqValid    = 3'b111;
        reqData     = '0;
        reqRob      = '0;
        reqControl  = '0;

        // Reset state, with valids asserted during reset
        step();
        step();
        check("rst_valid",  {63'd0, p_valid}, 64'd0);
        check("rst_data",   {32'd0, p_data},  64'd0);
        check("rst_src",    {62'd0, p_src},   64'd0);
        check("rst_ready_p", {61'd0, p_ready}, 64'd7);
        check("rst_ready_r", {61'd0, r_ready}, 64'd7);
        reqValid    = 3'b000;
        globalReset = 1'b1;

        // Single result on channel 1, two-edge latency
        reqValid = 3'b010;
        set_ch(1, 32'h0000_1234, 3'd5, 7'h55);
        step();
        check("lat_valid_early", {63'd0, p_valid}, 64'd0);
        reqValid = 3'b000;
        step();
        check("one_valid", {63'd0, p_valid}, 64'd1);
        check("one_data",  {32'd0, p_data},  64'h1234);
        check("one_rob",   {61'd0, p_rob},   64'd5);
        check("one_ctrl",  {57'd0, p_ctrl},  64'h55);
        check("one_src",   {62'd0, p_src},   64'd1);
        check("one_src_r", {62'd0, r_src},   64'd1);
        step();
        check("one_idle",  {63'd0, p_valid}, 64'd0);
        check("one_hold",  {32'd0, p_data},  64'h1234);

        // All three channels once: order 0,1,2 in both modes
        do_reset();
        reqValid = 3'b111;
        set_ch(0, 32'hA0, 3'd0, 7'h00);
        set_ch(1, 32'hA1, 3'd1, 7'h01);
        set_ch(2, 32'hA2, 3'd2, 7'h02);
        step();
        reqValid = 3'b000;
        check("rr_empty", {63'd0, r_valid}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rr_src",   {62'd0, r_src},  64'(k));
            check("rr_data",  {32'd0, r_data}, 64'(32'hA0 + k));
            check("pr_src",   {62'd0, p_src},  64'(k));
        end
        step();
        check("rr_done", {63'd0, r_valid}, 64'd0);

        // Channel 0 fed every cycle starves channels 1 and 2
        do_reset();
        reqValid = 3'b111;
        set_ch(0, 32'hB0, 3'd0, 7'h00);
        set_ch(1, 32'hC1, 3'd1, 7'h11);
        set_ch(2, 32'hC2, 3'd2, 7'h22);
        step();
        check("prio_empty", {63'd0, p_valid}, 64'd0);
        for (int k = 1; k < 4; k++) begin
            reqValid = 3'b001;
            set_ch(0, 32'hB0 + 32'(k), 3'd0, 7'h00);
            step();
            check("prio_src0",  {62'd0, p_src},  64'd0);
            check("prio_data0", {32'd0, p_data}, 64'(32'hB0 + k - 1));
        end
        reqValid = 3'b000;
        step();
        check("prio_last0", {32'd0, p_data}, 64'hB3);
        step();
        check("prio_src1",  {62'd0, p_src},  64'd1);
        check("prio_data1", {32'd0, p_data}, 64'hC1);
        step();
        check("prio_src2",  {62'd0, p_src},  64'd2);
        check("prio_data2", {32'd0, p_data}, 64'hC2);
        step();
        check("prio_idle",  {63'd0, p_valid}, 64'd0);

        // Backpressure on channel 2 while channel 0 holds the bus
        do_reset();
        for (int k = 0; k < 4; k++) begin
            reqValid = 3'b101;
            set_ch(0, 32'hD0 + 32'(k), 3'd0, 7'h00);
            set_ch(2, 32'hE0 + 32'(k), 3'd4, 7'h33);
            step();
            if (k == 1) begin
                check("bp_ready1", {61'd0, p_ready}, 64'd3);
                check("bp_d0",     {32'd0, p_data},  64'hD0);
            end else if (k == 2) begin
                check("bp_ready2", {61'd0, p_ready}, 64'd3);
            end else begin
                check("bp_src",    {62'd0, p_src},   64'd0);
            end
        end
        reqValid = 3'b000;
        step();
        check("bp_d3",    {32'd0, p_data}, 64'hD3);
        step();
        check("bp_e0_src", {62'd0, p_src},  64'd2);
        check("bp_e0",     {32'd0, p_data}, 64'hE0);
        step();
        check("bp_e1",     {32'd0, p_data}, 64'hE1);
        check("bp_ready3", {61'd0, p_ready}, 64'd7);
        step();
        check("bp_idle",   {63'd0, p_valid}, 64'd0);

        // Flush with partly full buffers and valids high
        do_reset();
        reqValid = 3'b110;
        set_ch(1, 32'hF1, 3'd1, 7'h01);
        set_ch(2, 32'hF2, 3'd2, 7'h02);
        step();
        flush    = 1'b1;
        reqValid = 3'b111;
        set_ch(0, 32'h60, 3'd0, 7'h00);
        step();
        check("fl_valid_p", {63'd0, p_valid}, 64'd0);
        check("fl_valid_r", {63'd0, r_valid}, 64'd0);
        check("fl_ready_p", {61'd0, p_ready}, 64'd7);
        check("fl_ready_r", {61'd0, r_ready}, 64'd7);
        flush    = 1'b0;
        reqValid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            step();
            check("fl_quiet_p", {63'd0, p_valid}, 64'd0);
            check("fl_quiet_r", {63'd0, r_valid}, 64'd0);
        end

        // Reset during traffic together with flush
        do_reset();
        reqValid = 3'b111;
        set_ch(0, 32'h70, 3'd3, 7'h40);
        set_ch(1, 32'h71, 3'd3, 7'h41);
        set_ch(2, 32'h72, 3'd3, 7'h42);
        step();
        reqValid = 3'b000;
        step();
        check("mid_valid", {63'd0, p_valid}, 64'd1);
        check("mid_data",  {32'd0, p_data},  64'h70);
        globalReset = 1'b0;
        flush       = 1'b1;
        reqValid    = 3'b111;
        step();
        check("mr_valid",   {63'd0, p_valid}, 64'd0);
        check("mr_data",    {32'd0, p_data},  64'd0);
        check("mr_rob",     {61'd0, p_rob},   64'd0);
        check("mr_ctrl",    {57'd0, p_ctrl},  64'd0);
        check("mr_src",     {62'd0, p_src},   64'd0);
        check("mr_ready_p", {61'd0, p_ready}, 64'd7);
        check("mr_valid_r", {63'd0, r_valid}, 64'd0);
        globalReset = 1'b1;
        flush       = 1'b0;
        reqValid    = 3'b111;
        set_ch(0, 32'h80, 3'd1, 7'h00);
        set_ch(1, 32'h81, 3'd1, 7'h00);
        set_ch(2, 32'h82, 3'd1, 7'h00);
        step();
        reqValid = 3'b000;
        step();
        check("post_valid", {63'd0, p_valid}, 64'd1);
        check("post_src_p", {62'd0, p_src},   64'd0);
        check("post_src_r", {62'd0, r_src},   64'd0);
        check("post_data",  {32'd0, r_data},  64'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
